// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: streams packed image and weight words over a 16-bit Avalon-MM
// master, accumulates lane products, adds bias, saturates/clamps and writes each node result back.
module fc_layer_engine #(
    parameter int unsigned N_IN     = 196,
    parameter int unsigned N_OUT    = 200,
    parameter int unsigned N_IMG    = 100,
    parameter int unsigned LANE_W   = 4,
    parameter int unsigned ACC_W    = 24,
    parameter bit          SAT_EN   = 1'b1,
    parameter bit          RELU_EN  = 1'b0,
    parameter logic [31:0] IMG_BASE = 32'd0,
    parameter logic [31:0] W_BASE   = 32'd158400,
    parameter logic [31:0] B_BASE   = 32'd157600,
    parameter logic [31:0] OUT_BASE = 32'd320800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        done,
    output logic        busy,
    output logic [31:0] SDRAM_address,
    output logic        SDRAM_readn,
    output logic        SDRAM_writen,
    output logic        SDRAM_chipselect,
    output logic [1:0]  SDRAM_byteenable,
    input  logic        SDRAM_waitrequest,
    input  logic        SDRAM_readdatavalid,
    input  logic [15:0] SDRAM_readdata,
    output logic [15:0] SDRAM_writedata
);

    localparam int LANES = 16 / LANE_W;

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StRdImg = 4'd1;
    localparam logic [3:0] StWtImg = 4'd2;
    localparam logic [3:0] StRdW   = 4'd3;
    localparam logic [3:0] StWtW   = 4'd4;
    localparam logic [3:0] StMac   = 4'd5;
    localparam logic [3:0] StRdB   = 4'd6;
    localparam logic [3:0] StWtB   = 4'd7;
    localparam logic [3:0] StBias  = 4'd8;
    localparam logic [3:0] StWr    = 4'd9;
    localparam logic [3:0] StNext  = 4'd10;
    localparam logic [3:0] StDone  = 4'd11;

    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(32767);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W + 1)'(-32768);

    logic [3:0]       state_q, state_d;
    logic [31:0]      k_q, k_d;
    logic [31:0]      n_q, n_d;
    logic [31:0]      i_q, i_d;
    // Running word offsets replace i*N_IN, n*N_IN and i*N_OUT+n multiplies.
    logic [31:0]      img_row_q, img_row_d;
    logic [31:0]      w_row_q, w_row_d;
    logic [31:0]      out_idx_q, out_idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]      img_q, img_d;
    logic [15:0]      w_q, w_d;
    logic [15:0]      bias_q, bias_d;
    logic [15:0]      wdata_q, wdata_d;

    logic [ACC_W-1:0]        mac_sum;
    logic [LANE_W-1:0]       lane_img;
    logic [LANE_W-1:0]       lane_w;
    logic signed [ACC_W:0]   bias_sum;
    logic [15:0]             result;

    // Lanes whose image value is zero contribute nothing; the sum wraps in ACC_W bits.
    always_comb begin
        mac_sum  = acc_q;
        lane_img = '0;
        lane_w   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_img = img_q[l*LANE_W +: LANE_W];
            lane_w   = w_q[l*LANE_W +: LANE_W];
            if (lane_img != '0) begin
                mac_sum = mac_sum + ACC_W'($signed(lane_w));
            end
        end
    end

    always_comb begin
        bias_sum = (ACC_W + 1)'($signed(acc_q)) + (ACC_W + 1)'($signed(bias_q));
        if (SAT_EN && (bias_sum > SAT_MAX)) begin
            result = 16'h7FFF;
        end else if (SAT_EN && (bias_sum < SAT_MIN)) begin
            result = 16'h8000;
        end else begin
            result = bias_sum[15:0];
        end
        if (RELU_EN && result[15]) begin
            result = 16'h0000;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        i_d       = i_q;
        img_row_d = img_row_q;
        w_row_d   = w_row_q;
        out_idx_d = out_idx_q;
        acc_d     = acc_q;
        img_d     = img_q;
        w_d       = w_q;
        bias_d    = bias_q;
        wdata_d   = wdata_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRdImg;
                    k_d       = '0;
                    n_d       = '0;
                    i_d       = '0;
                    img_row_d = '0;
                    w_row_d   = '0;
                    out_idx_d = '0;
                    acc_d     = '0;
                end
            end
            StRdImg: begin
                if (!SDRAM_waitrequest) state_d = StWtImg;
            end
            StWtImg: begin
                if (SDRAM_readdatavalid) begin
                    img_d   = SDRAM_readdata;
                    state_d = StRdW;
                end
            end
            StRdW: begin
                if (!SDRAM_waitrequest) state_d = StWtW;
            end
            StWtW: begin
                if (SDRAM_readdatavalid) begin
                    w_d     = SDRAM_readdata;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = mac_sum;
                if (k_q == N_IN - 1) begin
                    state_d = StRdB;
                end else begin
                    k_d     = k_q + 32'd1;
                    state_d = StRdImg;
                end
            end
            StRdB: begin
                if (!SDRAM_waitrequest) state_d = StWtB;
            end
            StWtB: begin
                if (SDRAM_readdatavalid) begin
                    bias_d  = SDRAM_readdata;
                    state_d = StBias;
                end
            end
            StBias: begin
                wdata_d = result;
                state_d = StWr;
            end
            StWr: begin
                if (!SDRAM_waitrequest) state_d = StNext;
            end
            StNext: begin
                acc_d     = '0;
                k_d       = '0;
                out_idx_d = out_idx_q + 32'd1;
                if (n_q == N_OUT - 1) begin
                    n_d       = '0;
                    w_row_d   = '0;
                    i_d       = i_q + 32'd1;
                    img_row_d = img_row_q + N_IN;
                    state_d   = (i_q == N_IMG - 1) ? StDone : StRdImg;
                end else begin
                    n_d     = n_q + 32'd1;
                    w_row_d = w_row_q + N_IN;
                    state_d = StRdImg;
                end
            end
            StDone: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            k_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            img_row_q <= '0;
            w_row_q   <= '0;
            out_idx_q <= '0;
            acc_q     <= '0;
            img_q     <= '0;
            w_q       <= '0;
            bias_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            i_q       <= i_d;
            img_row_q <= img_row_d;
            w_row_q   <= w_row_d;
            out_idx_q <= out_idx_d;
            acc_q     <= acc_d;
            img_q     <= img_d;
            w_q       <= w_d;
            bias_q    <= bias_d;
            wdata_q   <= wdata_d;
        end
    end

    // Address is a pure function of state and counters, which only move on exit from a
    // request state, so it stays stable through any waitrequest stall.
    always_comb begin
        case (state_q)
            StRdImg, StWtImg:     SDRAM_address = IMG_BASE + ((img_row_q + k_q) << 1);
            StRdW, StWtW, StMac:  SDRAM_address = W_BASE + ((w_row_q + k_q) << 1);
            StRdB, StWtB, StBias: SDRAM_address = B_BASE + (n_q << 1);
            StWr, StNext:         SDRAM_address = OUT_BASE + (out_idx_q << 1);
            default:              SDRAM_address = 32'd0;
        endcase
    end

    assign SDRAM_readn      = !((state_q == StRdImg) || (state_q == StRdW) || (state_q == StRdB));
    assign SDRAM_writen     = (state_q != StWr);
    assign SDRAM_chipselect = 1'b1;
    assign SDRAM_byteenable = 2'b11;
    assign SDRAM_writedata  = wdata_q;
    assign done             = (state_q == StDone);
    assign busy             = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_fc_layer_engine.sv
// Directed bench for fc_layer_engine: five instances with different geometry/saturation/ReLU,
// one shared SDRAM responder that serves whichever instance the current test drives.
module tb_fc_layer_engine;

    localparam int          NDUT     = 5;
    localparam logic [31:0] IMG_BASE = 32'd0;
    localparam logic [31:0] B_BASE   = 32'd157600;
    localparam logic [31:0] W_BASE   = 32'd158400;
    localparam logic [31:0] OUT_BASE = 32'd320800;
    localparam int          LIMIT    = 20000;

    // Instance 4 (N_IN=2, N_OUT=3, N_IMG=2), results in order i0n0..i1n2.
    localparam logic [15:0] EXP_G [6] = '{16'h0003, 16'h0007, 16'h00E0,
                                          16'h0004, 16'h0006, 16'h00F8};

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v  [NDUT];
    logic        done_w   [NDUT];
    logic        busy_w   [NDUT];
    logic [31:0] addr_w   [NDUT];
    logic        readn_w  [NDUT];
    logic        writen_w [NDUT];
    logic        cs_w     [NDUT];
    logic [1:0]  be_w     [NDUT];
    logic        wait_i   [NDUT];
    logic        valid_i  [NDUT];
    logic [15:0] wdata_w  [NDUT];
    logic [15:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_addr [$];
    logic [15:0] wr_data [$];
    logic [31:0] b_addr  [$];
    int          bus_err;

    logic [15:0] img_tab [2][2];
    logic [15:0] w_tab   [3][2];
    logic [15:0] b_tab   [3];

    always #5 clk = ~clk;

    // 0: basic, 1: ReLU, 2: long saturating, 3: long truncating, 4: multi-node/image
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fc_layer_engine #(
            .N_IN    ((g == 2 || g == 3) ? 1200 : (g == 4) ? 2 : 1),
            .N_OUT   ((g == 4) ? 3 : 1),
            .N_IMG   ((g == 4) ? 2 : 1),
            .LANE_W  (4),
            .ACC_W   (24),
            .SAT_EN  (g != 3),
            .RELU_EN (g == 1)
        ) u_dut (
            .clk                 (clk),
            .reset               (reset),
            .start               (start_v[g]),
            .done                (done_w[g]),
            .busy                (busy_w[g]),
            .SDRAM_address       (addr_w[g]),
            .SDRAM_readn         (readn_w[g]),
            .SDRAM_writen        (writen_w[g]),
            .SDRAM_chipselect    (cs_w[g]),
            .SDRAM_byteenable    (be_w[g]),
            .SDRAM_waitrequest   (wait_i[g]),
            .SDRAM_readdatavalid (valid_i[g]),
            .SDRAM_readdata      (rdata),
            .SDRAM_writedata     (wdata_w[g])
        );
    end

    function automatic logic [15:0] mem_rd(input logic [31:0] a, input int n_in);
        int idx;
        int row;
        int k;
        if (a < B_BASE) begin
            idx = int'((a - IMG_BASE) >> 1);
            row = idx / n_in;
            k   = idx % n_in;
            return img_tab[row % 2][(k > 1) ? 1 : k];
        end else if (a < W_BASE) begin
            idx = int'((a - B_BASE) >> 1);
            return b_tab[idx % 3];
        end else begin
            idx = int'((a - W_BASE) >> 1);
            row = idx / n_in;
            k   = idx % n_in;
            return w_tab[row % 3][(k > 1) ? 1 : k];
        end
    endfunction

    task automatic set_single(input logic [15:0] img, input logic [15:0] w, input logic [15:0] b);
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) img_tab[r][c] = img;
        for (int r = 0; r < 3; r++) for (int c = 0; c < 2; c++) w_tab[r][c] = w;
        for (int r = 0; r < 3; r++) b_tab[r] = b;
    endtask

    task automatic set_geom();
        img_tab[0][0] = 16'h1111; img_tab[0][1] = 16'h0000;
        img_tab[1][0] = 16'h0F00; img_tab[1][1] = 16'h2000;
        w_tab[0][0] = 16'hFFF1; w_tab[0][1] = 16'h0001;
        w_tab[1][0] = 16'h1234; w_tab[1][1] = 16'h7000;
        w_tab[2][0] = 16'h8888; w_tab[2][1] = 16'h00F0;
        b_tab[0] = 16'h0005; b_tab[1] = 16'hFFFD; b_tab[2] = 16'h0100;
    endtask

    // Cycle-level SDRAM slave: stalls each transaction `waits` cycles, returns read data one
    // cycle after acceptance, logs writes and bias reads, and counts bus protocol violations.
    task automatic serve(input int s, input int waits, input int n_in, input bit abort_w,
                         output bit tmo, output bit aborted);
        int          wcnt;
        int          cyc;
        bit          pend;
        logic [31:0] paddr;
        logic [31:0] haddr;
        logic [15:0] hdata;
        wr_addr.delete();
        wr_data.delete();
        b_addr.delete();
        bus_err = 0;
        aborted = 1'b0;
        wcnt    = 0;
        pend    = 1'b0;
        paddr   = '0;
        haddr   = '0;
        hdata   = '0;
        start_v[s] = 1'b1;
        for (cyc = 0; cyc < LIMIT; cyc++) begin
            @(negedge clk);
            wait_i[s]  = 1'b0;
            valid_i[s] = 1'b0;
            if (done_w[s]) break;
            if (!busy_w[s]) bus_err++;
            if (!readn_w[s] && !writen_w[s]) bus_err++;
            if (pend) begin
                if (!readn_w[s] || !writen_w[s]) bus_err++;
                valid_i[s] = 1'b1;
                rdata      = mem_rd(paddr, n_in);
                pend       = 1'b0;
                if (abort_w && paddr >= W_BASE) begin
                    reset      = 1'b1;
                    start_v[s] = 1'b0;
                    aborted    = 1'b1;
                    break;
                end
            end else if (!readn_w[s] || !writen_w[s]) begin
                if (wcnt == 0) begin
                    haddr = addr_w[s];
                    hdata = wdata_w[s];
                end else if (addr_w[s] !== haddr || (!writen_w[s] && wdata_w[s] !== hdata)) begin
                    bus_err++;
                end
                if (wcnt < waits) begin
                    wait_i[s] = 1'b1;
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (!readn_w[s]) begin
                        pend  = 1'b1;
                        paddr = addr_w[s];
                        if (paddr >= B_BASE && paddr < W_BASE) b_addr.push_back(paddr);
                    end else begin
                        wr_addr.push_back(addr_w[s]);
                        wr_data.push_back(wdata_w[s]);
                    end
                end
            end else if (wcnt != 0) begin
                bus_err++;
            end
        end
        tmo = (cyc >= LIMIT);
    endtask

    // Full run: serve until DONE, confirm DONE holds while start stays high, then release.
    task automatic do_run(input int s, input int waits, input int n_in,
                          output bit tmo, output bit hold_ok, output bit idle_ok);
        bit ab;
        serve(s, waits, n_in, 1'b0, tmo, ab);
        hold_ok = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (!done_w[s] || busy_w[s] || !readn_w[s] || !writen_w[s]) hold_ok = 1'b0;
        end
        start_v[s] = 1'b0;
        @(negedge clk);
        idle_ok = !done_w[s] && !busy_w[s];
    endtask

    task automatic test_reset();
        logic [52:0] got;
        logic [52:0] exp;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp = {1'b1, 1'b1, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, 2'b11};
        for (int s = 0; s < NDUT; s++) begin
            got = {readn_w[s], writen_w[s], addr_w[s], wdata_w[s], done_w[s], busy_w[s],
                   cs_w[s], be_w[s]};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: got %h expected %h", s, got, exp);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit          tmo;
        bit          hold_ok;
        bit          idle_ok;
        logic [15:0] got;
        // w=FFF1 lanes 1,-1,-1,-1 sum to -2; plus bias 5 gives 3
        set_single(16'h1111, 16'hFFF1, 16'h0005);
        do_run(0, 0, 1, tmo, hold_ok, idle_ok);
        n_tests++;
        if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0b expected 0", tmo); end
        n_tests++;
        if (wr_data.size() != 1) begin
            n_fail++; $display("FAIL basic_write_count: got %0d expected 1", wr_data.size());
        end
        got = (wr_data.size() > 0) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'h0003) begin n_fail++; $display("FAIL basic_data: got %h expected 0003", got); end
        n_tests++;
        if (wr_addr.size() == 0 || wr_addr[0] !== OUT_BASE) begin
            n_fail++; $display("FAIL basic_addr: got %0d writes expected one at %0d", wr_addr.size(), OUT_BASE);
        end
        n_tests++;
        if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %0b expected 1", hold_ok); end
        n_tests++;
        if (idle_ok !== 1'b1) begin n_fail++; $display("FAIL done_release: got %0b expected 1", idle_ok); end
        n_tests++;
        if (bus_err != 0) begin n_fail++; $display("FAIL basic_bus: got %0d errors expected 0", bus_err); end
    endtask

    task automatic test_relu();
        bit          tmo;
        bit          hold_ok;
        bit          idle_ok;
        logic [15:0] got;
        set_single(16'h0000, 16'hFFF1, 16'hFFFD);
        do_run(0, 0, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'hFFFD) begin n_fail++; $display("FAIL zero_img_norelu: got %h expected fffd", got); end
        do_run(1, 0, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'h0000) begin n_fail++; $display("FAIL zero_img_relu: got %h expected 0000", got); end
        // -2 + -3 = -5
        set_single(16'h1111, 16'hFFF1, 16'hFFFD);
        do_run(0, 0, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'hFFFB) begin n_fail++; $display("FAIL neg_norelu: got %h expected fffb", got); end
        do_run(1, 0, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'h0000) begin n_fail++; $display("FAIL neg_relu: got %h expected 0000", got); end
        set_single(16'h1111, 16'hFFF1, 16'h0005);
        do_run(1, 0, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (got !== 16'h0003) begin n_fail++; $display("FAIL pos_relu: got %h expected 0003", got); end
    endtask

    task automatic test_saturation();
        bit          tmo;
        bit          hold_ok;
        bit          idle_ok;
        logic [15:0] got;
        // 1200 words * 4 lanes * 7 = 33600 = 0x8340, beyond signed 16
        set_single(16'hFFFF, 16'h7777, 16'h0000);
        do_run(2, 0, 1200, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (tmo !== 1'b0 || got !== 16'h7FFF) begin
            n_fail++; $display("FAIL sat_on: got %h (timeout %0b) expected 7fff", got, tmo);
        end
        do_run(3, 0, 1200, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (tmo !== 1'b0 || got !== 16'h8340) begin
            n_fail++; $display("FAIL sat_off: got %h (timeout %0b) expected 8340", got, tmo);
        end
    endtask

    task automatic test_geometry(input int waits);
        bit          tmo;
        bit          hold_ok;
        bit          idle_ok;
        logic [15:0] got;
        logic [31:0] gota;
        set_geom();
        do_run(4, waits, 2, tmo, hold_ok, idle_ok);
        n_tests++;
        if (tmo !== 1'b0 || wr_data.size() != 6) begin
            n_fail++; $display("FAIL geom_count w%0d: got %0d writes expected 6", waits, wr_data.size());
        end
        for (int j = 0; j < 6; j++) begin
            got  = (j < wr_data.size()) ? wr_data[j] : 16'hxxxx;
            gota = (j < wr_addr.size()) ? wr_addr[j] : 32'hxxxxxxxx;
            n_tests++;
            if (got !== EXP_G[j]) begin
                n_fail++; $display("FAIL geom_data w%0d #%0d: got %h expected %h", waits, j, got, EXP_G[j]);
            end
            n_tests++;
            if (gota !== OUT_BASE + 32'(2 * j)) begin
                n_fail++; $display("FAIL geom_addr w%0d #%0d: got %0d expected %0d", waits, j, gota,
                                   OUT_BASE + 32'(2 * j));
            end
            gota = (j < b_addr.size()) ? b_addr[j] : 32'hxxxxxxxx;
            n_tests++;
            if (gota !== B_BASE + 32'(2 * (j % 3))) begin
                n_fail++; $display("FAIL bias_addr w%0d #%0d: got %0d expected %0d", waits, j, gota,
                                   B_BASE + 32'(2 * (j % 3)));
            end
        end
        n_tests++;
        if (bus_err != 0) begin n_fail++; $display("FAIL geom_bus w%0d: got %0d errors expected 0", waits, bus_err); end
    endtask

    task automatic test_wait_states();
        bit          tmo;
        bit          hold_ok;
        bit          idle_ok;
        logic [15:0] got;
        set_single(16'h1111, 16'hFFF1, 16'h0005);
        do_run(0, 5, 1, tmo, hold_ok, idle_ok);
        got = (wr_data.size() == 1) ? wr_data[0] : 16'hxxxx;
        n_tests++;
        if (tmo !== 1'b0 || got !== 16'h0003) begin
            n_fail++; $display("FAIL wait_data: got %h (timeout %0b) expected 0003", got, tmo);
        end
        n_tests++;
        if (bus_err != 0) begin n_fail++; $display("FAIL wait_stable: got %0d errors expected 0", bus_err); end
        test_geometry(5);
    endtask

    task automatic test_reset_mid_run();
        bit          tmo;
        bit          ab;
        logic [34:0] got;
        logic [34:0] exp;
        set_geom();
        serve(4, 0, 2, 1'b1, tmo, ab);
        n_tests++;
        if (ab !== 1'b1) begin n_fail++; $display("FAIL abort_reached: got %0b expected 1", ab); end
        @(negedge clk);
        exp = {1'b1, 1'b1, 1'b0, 32'd0};
        got = {readn_w[4], writen_w[4], busy_w[4], addr_w[4]};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL abort_idle: got %h expected %h", got, exp); end
        reset      = 1'b0;
        valid_i[4] = 1'b1;
        rdata      = 16'h1234;
        @(negedge clk);
        valid_i[4] = 1'b0;
        got = {readn_w[4], writen_w[4], busy_w[4], addr_w[4]};
        n_tests++;
        if (got !== exp || done_w[4] !== 1'b0) begin
            n_fail++; $display("FAIL late_valid: got %h done %0b expected %h done 0", got, done_w[4], exp);
        end
        test_geometry(0);
    endtask

    initial begin
        reset = 1'b1;
        rdata = '0;
        for (int s = 0; s < NDUT; s++) begin
            start_v[s] = 1'b0;
            wait_i[s]  = 1'b0;
            valid_i[s] = 1'b0;
        end
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_geometry(0);
        test_wait_states();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
